// File: rtl/tmr_fault_manager_if.sv
// Bus between the TMR voter bank / replica control and the fault manager.
// slave: the fault manager. master: the voter side that drives the mismatch
// flags and the recovery acknowledge.
interface tmr_fault_manager_if;
  logic       mis_a;
  logic       mis_b;
  logic       mis_c;
  logic       no_majority;
  logic       recover_ack;
  logic       err_ctrl_a;
  logic       err_ctrl_b;
  logic       err_ctrl_c;
  logic       recover_req;
  logic [1:0] recover_sel;
  logic       tmr_error;
  logic       fatal;

  modport master (
    output mis_a, mis_b, mis_c, no_majority, recover_ack,
    input  err_ctrl_a, err_ctrl_b, err_ctrl_c, recover_req, recover_sel,
    input  tmr_error, fatal
  );

  modport slave (
    input  mis_a, mis_b, mis_c, no_majority, recover_ack,
    output err_ctrl_a, err_ctrl_b, err_ctrl_c, recover_req, recover_sel,
    output tmr_error, fatal
  );
endinterface

// File: rtl/tmr_fault_manager.sv
// TMR fault manager: counts consecutive per-replica mismatches, masks a
// replica that crosses the threshold, runs a req/ack recovery of it and
// either unmasks it after a clean settle window or falls back to simplex
// (DEGRADED) / FATAL. All outputs are registered.
module tmr_fault_manager #(
  parameter int THRESH    = 4,
  parameter int SETTLE    = 8,
  parameter int MAX_TRIES = 2,
  parameter int ACK_TO    = 16
) (
  input logic               clk,
  input logic               rst,
  tmr_fault_manager_if.slave tmr
);
  localparam int CW  = $clog2(THRESH + 1);
  localparam int TW  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int TOW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]  THRESH_C    = CW'(THRESH);
  // Last-value comparisons avoid widening the counters by one bit.
  localparam logic [TW-1:0]  TRIES_LAST  = TW'(MAX_TRIES - 1);
  localparam logic [TOW-1:0] TO_LAST     = TOW'(ACK_TO - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {MONITOR, REQ, RESYNC, DEGRADED, FATAL} state_t;

  state_t         state;
  logic [2:0]     mis;
  logic [2:0]     err_ctrl;
  logic [CW-1:0]  cnt     [3];
  logic [CW-1:0]  cnt_inc [3];
  logic [2:0]     hit;
  logic [1:0]     pick_id;
  logic [1:0]     fault_id;
  logic [TW-1:0]  tries;
  logic [TOW-1:0] to_cnt;
  logic [SW-1:0]  clean;
  logic           recover_req;
  logic           tmr_error;
  logic           fatal;
  logic           mis_fault;
  logic           cnt_active;
  logic           fault_take;
  logic           resync_done;

  assign mis = {tmr.mis_c, tmr.mis_b, tmr.mis_a};

  // Next count per replica and "this replica crosses the threshold now";
  // masked replicas can never raise a hit.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      assign cnt_inc[gi] = !mis[gi] ? '0 :
                           (cnt[gi] == THRESH_C) ? THRESH_C : cnt[gi] + CW'(1);
      assign hit[gi]     = (cnt_inc[gi] == THRESH_C) && !err_ctrl[gi];
    end
  endgenerate

  // Lowest replica id wins when several thresholds are reached together.
  always_comb begin
    pick_id = 2'd0;
    if (hit[0])      pick_id = 2'd0;
    else if (hit[1]) pick_id = 2'd1;
    else if (hit[2]) pick_id = 2'd2;
  end

  // Mismatch flag of the replica currently under recovery.
  always_comb begin
    case (fault_id)
      2'd1:    mis_fault = mis[1];
      2'd2:    mis_fault = mis[2];
      default: mis_fault = mis[0];
    endcase
  end

  assign cnt_active  = (state == MONITOR) || (state == DEGRADED);
  assign fault_take  = (state == MONITOR) && !tmr.no_majority && (|hit);
  assign resync_done = (state == RESYNC) && !tmr.no_majority && !mis_fault &&
                       (clean == SETTLE_LAST);

  // Mismatch counters: live only while monitoring or degraded, frozen during
  // recovery, cleared when a recovered replica is readmitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (resync_done) begin
          cnt[i] <= '0;
        end else if (cnt_active) begin
          if (err_ctrl[i] || (fault_take && pick_id == 2'(i))) cnt[i] <= '0;
          else                                                  cnt[i] <= cnt_inc[i];
        end
      end
    end
  end

  // Supervisor FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MONITOR;
      err_ctrl    <= '0;
      fault_id    <= '0;
      tries       <= '0;
      to_cnt      <= '0;
      clean       <= '0;
      recover_req <= 1'b0;
      tmr_error   <= 1'b0;
      fatal       <= 1'b0;
    end else begin
      case (state)
        MONITOR: begin
          if (tmr.no_majority) begin
            state     <= FATAL;
            fatal     <= 1'b1;
            tmr_error <= 1'b1;
          end else if (|hit) begin
            state       <= REQ;
            err_ctrl    <= 3'(1) << pick_id;
            fault_id    <= pick_id;
            tries       <= '0;
            to_cnt      <= '0;
            recover_req <= 1'b1;
            tmr_error   <= 1'b1;
          end
        end
        REQ: begin
          // An ack in the timeout cycle still wins.
          if (tmr.recover_ack) begin
            state       <= RESYNC;
            recover_req <= 1'b0;
            clean       <= '0;
          end else if (to_cnt == TO_LAST) begin
            state       <= DEGRADED;
            recover_req <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        RESYNC: begin
          if (tmr.no_majority) begin
            state     <= FATAL;
            fatal     <= 1'b1;
            tmr_error <= 1'b1;
          end else if (mis_fault) begin
            if (tries < TRIES_LAST) begin
              state       <= REQ;
              tries       <= tries + TW'(1);
              to_cnt      <= '0;
              recover_req <= 1'b1;
            end else begin
              state <= DEGRADED;
            end
          end else if (clean == SETTLE_LAST) begin
            state     <= MONITOR;
            err_ctrl  <= '0;
            tmr_error <= 1'b0;
          end else begin
            clean <= clean + SW'(1);
          end
        end
        DEGRADED: begin
          if (tmr.no_majority || (|hit)) begin
            state <= FATAL;
            fatal <= 1'b1;
          end
        end
        FATAL: begin
          // Terminal until reset; err_ctrl stays as it was.
        end
        default: state <= MONITOR;
      endcase
    end
  end

  assign tmr.err_ctrl_a  = err_ctrl[0];
  assign tmr.err_ctrl_b  = err_ctrl[1];
  assign tmr.err_ctrl_c  = err_ctrl[2];
  assign tmr.recover_req = recover_req;
  assign tmr.recover_sel = fault_id;
  assign tmr.tmr_error   = tmr_error;
  assign tmr.fatal       = fatal;
endmodule
